// File: rtl/decryption_pkg.sv
// Shared constants and FIFO entry type for the decryption output path.
package decryption_pkg;

  localparam int unsigned SYS_DWIDTH = 8;
  localparam int unsigned MST_DWIDTH = 32;
  localparam int unsigned BPW        = MST_DWIDTH / SYS_DWIDTH;
  localparam int unsigned CNT_W      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned FILL_W     = CNT_W + 1;

  typedef struct packed {
    logic [MST_DWIDTH-1:0] data;
    logic [BPW-1:0]        keep;
    logic                  last;
  } out_word_t;

  localparam int unsigned OUT_WORD_W = $bits(out_word_t);

endpackage

// File: rtl/decryption_sync_fifo.sv
// Show-ahead synchronous FIFO; a pop frees a slot for a same-cycle push.
module decryption_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign level    = level_q;
  // Head entry is forced to zero while empty so stale storage never shows.
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/decryption_out_packer.sv
// Packs the decrypted character stream into little-endian words and queues
// them for the master side. Optional statistics counters are enabled with
// the DECRYPTION_OUT_PACKER_STATS_EN macro.
module decryption_out_packer
  import decryption_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_sys,
  input  logic                          rst,
  input  logic [SYS_DWIDTH-1:0]         data_i,
  input  logic                          valid_i,
  input  logic                          flush_i,
  output logic [MST_DWIDTH-1:0]         data_o,
  output logic [BPW-1:0]                keep_o,
  output logic                          last_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          full_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
`ifdef DECRYPTION_OUT_PACKER_STATS_EN
  ,
  output logic [15:0]                   char_cnt_o,
  output logic [7:0]                    drop_cnt_o
`endif
);

  logic [MST_DWIDTH-1:0] pack_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [FILL_W-1:0]     fill_c;
  out_word_t             word_c;
  out_word_t             head;
  logic                  commit_c;
  logic                  pop_c;
  logic                  drop_c;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Candidate word: held lanes plus this cycle's character in the next lane.
  always_comb begin
    word_c      = '0;
    word_c.data = pack_q;
    fill_c      = {1'b0, cnt_q} + FILL_W'(valid_i);
    for (int unsigned i = 0; i < BPW; i++) begin
      if (valid_i && (cnt_q == CNT_W'(i))) begin
        word_c.data[i*SYS_DWIDTH +: SYS_DWIDTH] = data_i;
      end
      word_c.keep[i] = (FILL_W'(i) < fill_c);
    end
    word_c.last = flush_i;
  end

  assign commit_c = (valid_i && (cnt_q == CNT_W'(BPW - 1))) ||
                    (flush_i && ((cnt_q != '0) || valid_i));
  assign valid_o  = ~fifo_empty;
  assign pop_c    = valid_o & ready_i;
  assign drop_c   = commit_c & fifo_full & ~pop_c;

  // Lane register and byte count; cleared on every commit, dropped or not.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pack_q <= '0;
      cnt_q  <= '0;
    end else if (commit_c) begin
      pack_q <= '0;
      cnt_q  <= '0;
    end else if (valid_i) begin
      pack_q <= word_c.data;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Sticky record of a committed word lost to a full FIFO.
  always_ff @(posedge clk_sys) begin
    if (rst)         overflow_o <= 1'b0;
    else if (drop_c) overflow_o <= 1'b1;
  end

  decryption_sync_fifo #(
    .WIDTH (OUT_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst       (rst),
    .push      (commit_c),
    .push_data (word_c),
    .pop       (pop_c),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

  assign data_o = head.data;
  assign keep_o = head.keep;
  assign last_o = head.last;
  assign full_o = fifo_full;

`ifdef DECRYPTION_OUT_PACKER_STATS_EN
  // Saturating counters of accepted characters and dropped words.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      char_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (valid_i && (char_cnt_o != '1)) char_cnt_o <= char_cnt_o + 16'd1;
      if (drop_c  && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decryption_out_packer.sv
// Self-checking bench for decryption_out_packer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_decryption_out_packer;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        flush_i;
  logic        ready_i;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;
  logic        valid_o;
  logic        full_o;
  logic        overflow_o;
  logic [3:0]  level_o;
`ifdef DECRYPTION_OUT_PACKER_STATS_EN
  logic [15:0] char_cnt_o;
  logic [7:0]  drop_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  decryption_out_packer #(.FIFO_DEPTH(8)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .keep_o     (keep_o),
    .last_o     (last_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .level_o    (level_o)
`ifdef DECRYPTION_OUT_PACKER_STATS_EN
    ,
    .char_cnt_o (char_cnt_o),
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  // Reference model: pending message bytes and a bounded queue of words.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t      mq[$];
  logic [7:0] pend[$];
  bit         m_ovf;
  int         m_chars;
  int         m_drops;

  task automatic model_edge();
    bit    pop;
    bit    full_before;
    bit    commit;
    word_t w;
    word_t gone;
    int    n;
    if (rst) begin
      mq.delete();
      pend.delete();
      m_ovf   = 0;
      m_chars = 0;
      m_drops = 0;
      return;
    end
    pop         = (mq.size() != 0) && ready_i;
    full_before = (mq.size() == 8);
    if (valid_i) begin
      pend.push_back(data_i);
      if (m_chars < 65535) m_chars++;
    end
    commit = (pend.size() == 4) || (flush_i && pend.size() != 0);
    w.data = '0;
    w.keep = '0;
    w.last = 1'b0;
    if (commit) begin
      n = pend.size();
      for (int k = 0; k < n; k++) w.data = w.data | (32'(pend[k]) << (8 * k));
      w.keep = 4'((1 << n) - 1);
      w.last = flush_i;
      pend.delete();
    end
    if (pop) gone = mq.pop_front();
    if (commit) begin
      if (full_before && !pop) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end else begin
        mq.push_back(w);
      end
    end
  endtask

  // One clock: model follows the DUT at the edge; return on the falling edge.
  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    data_i  = b;
    valid_i = 1'b1;
    flush_i = fl;
    tick();
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; data_i = '0;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({data_o, keep_o, last_o, valid_o, full_o, overflow_o, level_o} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got data=%h keep=%h last=%b valid=%b full=%b ovf=%b level=%0d want all 0",
               data_o, keep_o, last_o, valid_o, full_o, overflow_o, level_o);
    end
  endtask

  task automatic test_full_word();
    logic [7:0] b;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'h41 + 8'(i);
      send(b, 1'b0);
      vectors++;
      if (valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL full_word early valid (byte %0d): got %b want 0", i, valid_o);
      end
    end
    send(8'h44, 1'b0);
    vectors++;
    if ({valid_o, data_o, keep_o, last_o} !== {1'b1, 32'h44434241, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL full_word: got valid=%b data=%h keep=%h last=%b want 1 44434241 f 0",
               valid_o, data_o, keep_o, last_o);
    end
    tick();
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_word one-cycle valid: got %b want 0", valid_o);
    end
  endtask

  task automatic test_flush_partial();
    ready_i = 1'b1;
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    vectors++;
    if ({valid_o, data_o, keep_o, last_o} !== {1'b1, 32'h00002010, 4'h3, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_partial: got valid=%b data=%h keep=%h last=%b want 1 00002010 3 1",
               valid_o, data_o, keep_o, last_o);
    end
    tick();
  endtask

  task automatic test_flush_with_byte();
    ready_i = 1'b1;
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    vectors++;
    if ({valid_o, data_o, keep_o, last_o} !== {1'b1, 32'h00302010, 4'h7, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_with_byte: got valid=%b data=%h keep=%h last=%b want 1 00302010 7 1",
               valid_o, data_o, keep_o, last_o);
    end
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    vectors++;
    if ({valid_o, level_o} !== {1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL lone_flush: got valid=%b level=%0d want 0 0", valid_o, level_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  bytes [36];
    logic [31:0] exp_w;
    ready_i = 1'b0;
    for (int j = 0; j < 36; j++) bytes[j] = 8'($urandom);
    for (int j = 0; j < 36; j++) begin
      send(bytes[j], 1'b0);
      if (j == 31) begin
        vectors++;
        if ({full_o, level_o, overflow_o} !== {1'b1, 4'd8, 1'b0}) begin
          miscompares++;
          $display("FAIL overflow fill: got full=%b level=%0d ovf=%b want 1 8 0", full_o, level_o, overflow_o);
        end
      end
    end
    vectors++;
    if ({full_o, level_o, overflow_o} !== {1'b1, 4'd8, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow drop: got full=%b level=%0d ovf=%b want 1 8 1", full_o, level_o, overflow_o);
    end
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_w = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
      vectors++;
      if ({valid_o, data_o, keep_o, last_o} !== {1'b1, exp_w, 4'hF, 1'b0}) begin
        miscompares++;
        $display("FAIL overflow drain word %0d: got valid=%b data=%h keep=%h last=%b want 1 %h f 0",
                 k, valid_o, data_o, keep_o, last_o, exp_w);
      end
      tick();
    end
    vectors++;
    if ({valid_o, level_o, overflow_o} !== {1'b0, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow drained: got valid=%b level=%0d ovf=%b want 0 0 1", valid_o, level_o, overflow_o);
    end
  endtask

  task automatic test_full_with_pop();
    logic [7:0]  bytes [36];
    logic [31:0] exp_w;
    pulse_reset();
    ready_i = 1'b0;
    for (int j = 0; j < 36; j++) bytes[j] = 8'($urandom);
    for (int j = 0; j < 35; j++) send(bytes[j], 1'b0);
    ready_i = 1'b1;
    send(bytes[35], 1'b0);
    ready_i = 1'b0;
    exp_w = {bytes[7], bytes[6], bytes[5], bytes[4]};
    vectors++;
    if ({full_o, level_o, overflow_o, data_o} !== {1'b1, 4'd8, 1'b0, exp_w}) begin
      miscompares++;
      $display("FAIL full_with_pop: got full=%b level=%0d ovf=%b head=%h want 1 8 0 %h",
               full_o, level_o, overflow_o, data_o, exp_w);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0]  b [4];
    logic [31:0] exp_w;
    ready_i = 1'b0;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    pulse_reset();
    vectors++;
    if ({data_o, keep_o, last_o, valid_o, full_o, overflow_o, level_o} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_mid_word outputs: got data=%h keep=%h valid=%b full=%b level=%0d want all 0",
               data_o, keep_o, valid_o, full_o, level_o);
    end
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      send(b[i], 1'b0);
    end
    exp_w = {b[3], b[2], b[1], b[0]};
    vectors++;
    if ({valid_o, level_o, data_o, keep_o, last_o} !== {1'b1, 4'd1, exp_w, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_word clean word: got valid=%b level=%0d data=%h keep=%h last=%b want 1 1 %h f 0",
               valid_o, level_o, data_o, keep_o, last_o, exp_w);
    end
    ready_i = 1'b1;
    tick();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 800; c++) begin
      data_i  = 8'($urandom);
      valid_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 7) == 0);
      ready_i = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      tick();
      vectors++;
      if ({valid_o, full_o, overflow_o, level_o} !==
          {mq.size() != 0, mq.size() == 8, m_ovf, 4'(mq.size())}) begin
        miscompares++;
        $display("FAIL random status cycle %0d: got valid=%b full=%b ovf=%b level=%0d want level=%0d ovf=%b",
                 c, valid_o, full_o, overflow_o, level_o, mq.size(), m_ovf);
      end
      if (mq.size() != 0) begin
        vectors++;
        if ({data_o, keep_o, last_o} !== {mq[0].data, mq[0].keep, mq[0].last}) begin
          miscompares++;
          $display("FAIL random head cycle %0d: got data=%h keep=%h last=%b want %h %h %b",
                   c, data_o, keep_o, last_o, mq[0].data, mq[0].keep, mq[0].last);
        end
      end
`ifdef DECRYPTION_OUT_PACKER_STATS_EN
      vectors++;
      if ({char_cnt_o, drop_cnt_o} !== {16'(m_chars), 8'(m_drops)}) begin
        miscompares++;
        $display("FAIL random stats cycle %0d: got chars=%0d drops=%0d want %0d %0d",
                 c, char_cnt_o, drop_cnt_o, m_chars, m_drops);
      end
`endif
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_with_byte();
    test_overflow();
    test_full_with_pop();
    test_reset_mid_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
